seven_seg_scan_driver: RTL

//  Time-multiplexed 4-digit seven-segment driver. It consumes the BCD stopwatch digits
//  (sec_tenths, sec_ones, sec_tens, min_ones) produced by the counter chain.
//  It scans one digit per refresh tick onto shared segment lines. All four digits are

---
 rtl/seven_seg_scan_driver_if.sv | 19 +
 rtl/seven_seg_scan_driver.sv | 88 ++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: digit/hold inputs and multiplexed an/seg/dp outputs of the scan driver
interface seven_seg_scan_driver_if;
  logic       Hold;
  logic [3:0] sec_tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  modport master (
    output Hold, sec_tenths, sec_ones, sec_tens, min_ones,
    input  an, seg, dp
  );
  modport slave (
    input  Hold, sec_tenths, sec_ones, sec_tens, min_ones,
    output an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 4-digit time-multiplexed 7-seg driver with per-frame snapshot; define LEADING_ZERO_BLANK_EN to blank leading zeros
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic                   SysClk,
  input logic                   Reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TOP = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          tick;
  logic          load;
  logic [1:0]    idx_n;
  logic [15:0]   snap_n;
  logic [3:0]    digit;
  logic [6:0]    glyph;
  logic [3:0]    onehot;
  logic          blank_seg;
  logic          blank_dp;
  logic          dp_on;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction
  // next-slot outputs: the snapshot used for the new digit already includes a frame-start load
  always_comb begin
    tick   = div_cnt == TOP;
    idx_n  = idx + 2'd1;
    load   = tick && idx == 2'd3 && !bus.Hold;
    snap_n = load ? {bus.min_ones, bus.sec_tens, bus.sec_ones, bus.sec_tenths} : snap;
    digit  = snap_n[{idx_n, 2'b00} +: 4];
    glyph  = decode(digit);
    onehot = 4'b0001 << idx_n;
`ifdef LEADING_ZERO_BLANK_EN
    blank_dp  = idx_n == 2'd3 && snap_n[15:12] == 4'd0;
    blank_seg = blank_dp || (idx_n == 2'd2 && snap_n[15:8] == 8'd0);
`else
    blank_dp  = 1'b0;
    blank_seg = 1'b0;
`endif
    dp_on = idx_n[0] && !blank_dp;
    an_n  = blank_seg ? AN_OFF : (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    seg_n = blank_seg ? SEG_OFF : (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
    dp_n  = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;
  end
  // refresh divider, slot index, snapshot and registered display outputs
  always_ff @(posedge SysClk) begin
    if (!Reset) begin
      div_cnt <= '0;
      idx     <= 2'd3;
      snap    <= '0;
      bus.an  <= AN_OFF;
      bus.seg <= SEG_OFF;
      bus.dp  <= DP_OFF;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        idx     <= idx_n;
        snap    <= snap_n;
        bus.an  <= an_n;
        bus.seg <= seg_n;
        bus.dp  <= dp_n;
      end
    end
  end
endmodule
